// File: rtl/fetch_decode_buffer.sv
// Per-thread instruction FIFOs between fetch and decode: round-robin thread
// selection toward decode, per-thread fetch back-pressure and branch flush.
package fetch_decode_buffer_pkg;
  typedef enum logic {
    Single_Threaded = 1'b0,
    Multi_Threaded  = 1'b1
  } multithreading_mode_t;
endpackage

module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int unsigned THR          = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STALL_MARGIN = 2,
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned PC_W         = 32,
  localparam int unsigned TID_W       = (THR > 1) ? $clog2(THR) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  multithreading_mode_t mt_mode,
  input  logic                 fetch_valid,
  input  logic [INSTR_W-1:0]   fetch_instr,
  input  logic [PC_W-1:0]      fetch_pc,
  input  logic [TID_W-1:0]     fetch_thread_id,
  input  logic                 fetch_xcpt_itlb_miss,
  input  logic                 fetch_xcpt_bus_error,
  input  logic [THR-1:0]       flush,
  output logic [THR-1:0]       stall_fetch,
  output logic                 decode_valid,
  input  logic                 decode_ready,
  output logic [INSTR_W-1:0]   decode_instr,
  output logic [PC_W-1:0]      decode_pc,
  output logic [TID_W-1:0]     decode_thread_id,
  output logic                 decode_xcpt_itlb_miss,
  output logic                 decode_xcpt_bus_error,
  output logic                 overflow_err
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned STALL_AT = DEPTH - STALL_MARGIN;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               itlb_miss;
    logic               bus_error;
  } entry_t;

  entry_t           mem [THR][DEPTH];
  logic [PTR_W-1:0] rd_ptr [THR];
  logic [PTR_W-1:0] wr_ptr [THR];
  logic [OCC_W-1:0] occ [THR];
  logic [TID_W-1:0] last_grant;
  logic [TID_W-1:0] held_sel;
  logic             held;

  logic [THR-1:0]   eligible, nonempty, full, push_req, push, pop, drop_full;
  logic [TID_W-1:0] cand, rr_sel, sel;
  logic             xfer;
  entry_t           fetch_entry, head;

  assign fetch_entry = '{fetch_instr, fetch_pc, fetch_xcpt_itlb_miss, fetch_xcpt_bus_error};

  // Thread status; only thread 0 participates in single-threaded mode
  always_comb begin
    eligible    = '0;
    nonempty    = '0;
    full        = '0;
    stall_fetch = '0;
    for (int unsigned t = 0; t < THR; t++) begin
      eligible[t]    = (mt_mode == Multi_Threaded) || (t == 0);
      nonempty[t]    = eligible[t] && (occ[t] != '0);
      full[t]        = (occ[t] == OCC_W'(DEPTH));
      stall_fetch[t] = eligible[t] && (occ[t] >= OCC_W'(STALL_AT));
    end
  end

  // Round-robin search starting after the last granted thread
  always_comb begin
    cand   = '0;
    rr_sel = '0;
    for (int unsigned i = THR; i >= 1; i--) begin
      cand = TID_W'((32'(last_grant) + i) % THR);
      if (nonempty[cand]) rr_sel = cand;
    end
  end

  // A presented-but-unaccepted entry keeps its thread until it transfers
  assign sel          = held ? held_sel : rr_sel;
  assign decode_valid = nonempty[sel] && !flush[sel];
  assign xfer         = decode_valid && decode_ready;

  assign head                  = mem[sel][rd_ptr[sel]];
  assign decode_instr          = head.instr;
  assign decode_pc             = head.pc;
  assign decode_thread_id      = sel;
  assign decode_xcpt_itlb_miss = head.itlb_miss;
  assign decode_xcpt_bus_error = head.bus_error;

  // A full FIFO still accepts a push when its head leaves the same cycle
  always_comb begin
    push_req  = '0;
    push      = '0;
    pop       = '0;
    drop_full = '0;
    for (int unsigned t = 0; t < THR; t++) begin
      pop[t]       = xfer && (sel == TID_W'(t));
      push_req[t]  = fetch_valid && (fetch_thread_id == TID_W'(t)) && eligible[t] && !flush[t];
      push[t]      = push_req[t] && (!full[t] || pop[t]);
      drop_full[t] = push_req[t] && full[t] && !pop[t];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < THR; t++) begin
        rd_ptr[t] <= '0;
        wr_ptr[t] <= '0;
        occ[t]    <= '0;
      end
      last_grant   <= TID_W'(THR - 1);
      held         <= 1'b0;
      held_sel     <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < THR; t++) begin
        if (flush[t]) begin
          rd_ptr[t] <= '0;
          wr_ptr[t] <= '0;
          occ[t]    <= '0;
        end else begin
          if (push[t]) wr_ptr[t] <= wr_ptr[t] + PTR_W'(1);
          if (pop[t])  rd_ptr[t] <= rd_ptr[t] + PTR_W'(1);
          if (push[t] && !pop[t])      occ[t] <= occ[t] + OCC_W'(1);
          else if (pop[t] && !push[t]) occ[t] <= occ[t] - OCC_W'(1);
        end
      end
      if (xfer) last_grant <= sel;
      held     <= decode_valid && !decode_ready;
      held_sel <= sel;
      if (|drop_full) overflow_err <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clock) begin
    for (int unsigned t = 0; t < THR; t++) begin
      if (push[t]) mem[t][wr_ptr[t]] <= fetch_entry;
    end
  end

endmodule
